// File: rtl/ifetch.sv
// Instruction fetch front end: owns the fetch PC, one outstanding bus request, valid/ready hand-off to decode.
// Latency: data_ok in cycle N -> inst_valid in N+1; decode accept in M -> next request in M+1.
// Backpressure: holds the instruction while inst_ready=0; a redirect kills held or in-flight wrong-path work.
module ifetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic [63:0] req_addr_q;
    logic [31:0] inst_q;
    logic [63:0] inst_pc_q;

    // Fetch FSM: a redirect outranks every other event in every state.
    // DROP means a stale request is still on the bus and its response must be swallowed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            inst_q     <= 32'd0;
            inst_pc_q  <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_pc;
                        req_addr_q <= redirect_pc;
                    end else begin
                        req_addr_q <= pc_q;
                    end
                    state_q <= REQ;
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                        if (iresp_data_ok) begin
                            // Response arrived with the redirect: discard it and refetch at once.
                            req_addr_q <= redirect_pc;
                            state_q    <= REQ;
                        end else begin
                            // Request stays up with the old address until its response drains.
                            state_q <= DROP;
                        end
                    end else if (iresp_data_ok) begin
                        inst_q    <= iresp_data;
                        inst_pc_q <= req_addr_q;
                        pc_q      <= req_addr_q + 64'd4;
                        state_q   <= HOLD;
                    end
                end
                DROP: begin
                    if (iresp_data_ok) begin
                        if (redirect_valid) begin
                            pc_q       <= redirect_pc;
                            req_addr_q <= redirect_pc;
                        end else begin
                            req_addr_q <= pc_q;
                        end
                        state_q <= REQ;
                    end else if (redirect_valid) begin
                        // Latest redirect wins while the stale response is pending.
                        pc_q <= redirect_pc;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_pc;
                        req_addr_q <= redirect_pc;
                        state_q    <= REQ;
                    end else if (inst_ready) begin
                        req_addr_q <= pc_q;
                        state_q    <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from registers, except inst_valid which a redirect kills combinationally.
    always_comb begin
        ireq_valid = (state_q == REQ) || (state_q == DROP);
        ireq_addr  = req_addr_q;
        inst_valid = (state_q == HOLD) && !redirect_valid;
        inst       = inst_q;
        inst_pc    = inst_pc_q;
    end

endmodule
